seg7_frame_decoder: RTL and testbench
=====================================

SEG7_FRAME_DECODER -- requirements
Module: seg7_frame_decoder

Interface
REQ-001 SHALL have port CLOCK_50  in  1  single system clock; all logic on posedge.
REQ-002 SHALL have port reset_n  in  1  reset, asynchronous, active-low.
REQ-003 SHALL have port frame_stb  in  1  one-cycle strobe; the three seg inputs hold a new frame.
REQ-004 SHALL have ports seg2, seg1, seg0  in  7 each  a_to_g patterns (active-low, team BCD_2_7Seg encoding); seg2 is the most significant position.
REQ-005 SHALL have port bcd_out  out  36  nine captured digits, digit8 in [35:32] down to digit0 in [3:0].
REQ-006 SHALL have port value  out  36  binary value of the nine digits, zero-extended.
REQ-007 SHALL have port valid  out  1  one-cycle pulse when value/bcd_out update.
REQ-008 SHALL have port locked  out  1  high after the first successful decode, until an error or reset.
REQ-009 SHALL have port err  out  1  one-cycle pulse on a protocol or pattern error.

Function
REQ-010 SHALL decode each 7-bit pattern to a digit 0-9, to BLANK (7'b1111111), or to ILLEGAL (any other pattern, including A-F).
REQ-011 SHALL implement states HUNT, SYNC, G2, G1, G0, CONV; only a cycle with frame_stb=1 advances state, except in CONV.
REQ-012 In HUNT: an all-BLANK frame SHALL move to G2; any other frame SHALL be ignored, with no err.
REQ-013 In SYNC: an all-BLANK frame SHALL move to G2; any other frame SHALL pulse err, clear locked and move to HUNT.
REQ-014 In G2: an all-BLANK frame SHALL stay in G2 (repeated sync).
REQ-015 In G2: an all-digit frame SHALL latch digits 8..6 and move to G1.
REQ-016 In G1 and G0: an all-digit frame SHALL latch digits 5..3 (G1) or 2..0 (G0) and move to the next state.
REQ-017 In G1 and G0: an all-BLANK frame SHALL pulse err, clear locked and move to G2, discarding partial digits.
REQ-018 In G2, G1 and G0: a frame that contains any ILLEGAL pattern, or that mixes BLANK and digits, SHALL pulse err, clear locked and move to HUNT.
REQ-019 CONV SHALL last exactly 9 cycles; each cycle SHALL compute acc <= acc*10 + digit, processing the MSD first, with acc cleared on entry.
REQ-020 acc SHALL be 30 bits wide, which is sufficient for a maximum of 999999999.
REQ-021 For a G0 strobe at cycle t, value and bcd_out SHALL update and valid SHALL pulse at t+10; locked SHALL then be set.
REQ-022 An all-BLANK frame strobed during CONV SHALL set sync_seen; at the end of CONV the FSM SHALL go to G2 if sync_seen is set, otherwise to SYNC.
REQ-023 A non-BLANK frame strobed during CONV SHALL abort the conversion: no valid pulse, err pulse, locked cleared, next state HUNT.
REQ-024 value and bcd_out SHALL hold their last values between valid pulses and on error.

Reset
REQ-025 While reset_n=0, the state SHALL be HUNT.
REQ-026 While reset_n=0, value, bcd_out, acc, sync_seen, valid, err and locked SHALL all be 0.
REQ-027 Reset asserted during any state, including mid-CONV, SHALL take effect immediately, with no valid pulse afterward.

Configuration
REQ-028 Macro SEG7_DEC_BIN_CONV_EN defined: the CONV state and binary value output SHALL be present, as specified above.
REQ-029 Macro SEG7_DEC_BIN_CONV_EN undefined: CONV SHALL be omitted, value SHALL be tied to 0, and valid and bcd_out SHALL update at t+1 after the G0 strobe.
REQ-030 With the macro undefined, the G0 state SHALL return to SYNC.

Structure
REQ-031 A shared package SHALL hold the state encoding, the BLANK pattern constant, the digit pattern constants 0-9, and the DIGITS=9 and VAL_W=36 constants.
REQ-032 There SHALL be one sub-module, seg7_to_bcd: combinational, 7-bit pattern in; 4-bit digit, is_blank and is_illegal out; instantiated three times.

Verification
REQ-033 The bench SHALL cover: reset, then frames BLANK, "123", "456", "789" -> valid at G0 stb+10, value=123456789 (0x75BCD15), bcd_out=0x123456789, locked=1.
REQ-034 The bench SHALL cover: BLANK, "999", "999", "999" -> value=999999999 (0x3B9AC9FF), no overflow.
REQ-035 The bench SHALL cover: after lock, BLANK, "123", then a frame with seg1 showing "A" -> err pulse, locked=0, state HUNT, value unchanged.
REQ-036 The bench SHALL cover: a BLANK frame strobed 3 cycles into CONV -> valid still pulses, and the next "456" frame is accepted as G2.
REQ-037 The bench SHALL cover: a completed conversion followed by a digit frame with no BLANK -> err, HUNT, locked=0.
REQ-038 The bench SHALL cover: reset_n pulsed low at CONV cycle 5 -> no valid, and all outputs are 0 on the following cycle.

Source files
------------

// File: rtl/seg7_frame_decoder_pkg.sv
// Shared types and constants for the seven-segment frame decoder.
// SEG7_DEC_BIN_CONV_EN adds the CONV state for binary conversion.
package seg7_frame_decoder_pkg;

  localparam int DIGITS = 9;
  localparam int VAL_W  = 36;
  localparam int ACC_W  = 30;

  // Active-low a_to_g, bit 6 is segment a
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_0 = 7'b0000001;
  localparam logic [6:0] SEG_1 = 7'b1001111;
  localparam logic [6:0] SEG_2 = 7'b0010010;
  localparam logic [6:0] SEG_3 = 7'b0000110;
  localparam logic [6:0] SEG_4 = 7'b1001100;
  localparam logic [6:0] SEG_5 = 7'b0100100;
  localparam logic [6:0] SEG_6 = 7'b0100000;
  localparam logic [6:0] SEG_7 = 7'b0001111;
  localparam logic [6:0] SEG_8 = 7'b0000000;
  localparam logic [6:0] SEG_9 = 7'b0000100;

  typedef enum logic [2:0] {
    ST_HUNT,
    ST_SYNC,
    ST_G2,
    ST_G1,
`ifdef SEG7_DEC_BIN_CONV_EN
    ST_G0,
    ST_CONV
`else
    ST_G0
`endif
  } state_t;

endpackage

// File: rtl/seg7_to_bcd.sv
// Classifies one seven-segment pattern as digit, blank or illegal.
// Purely combinational.
module seg7_to_bcd
  import seg7_frame_decoder_pkg::*;
(
  input  logic [6:0] i_seg,
  output logic [3:0] o_digit,
  output logic       o_blank,
  output logic       o_illegal
);

  always_comb begin
    o_digit   = 4'd0;
    o_blank   = 1'b0;
    o_illegal = 1'b0;
    unique case (i_seg)
      SEG_0:     o_digit = 4'd0;
      SEG_1:     o_digit = 4'd1;
      SEG_2:     o_digit = 4'd2;
      SEG_3:     o_digit = 4'd3;
      SEG_4:     o_digit = 4'd4;
      SEG_5:     o_digit = 4'd5;
      SEG_6:     o_digit = 4'd6;
      SEG_7:     o_digit = 4'd7;
      SEG_8:     o_digit = 4'd8;
      SEG_9:     o_digit = 4'd9;
      SEG_BLANK: o_blank = 1'b1;
      default:   o_illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/seg7_frame_decoder.sv
// Frame-synchronised nine-digit seven-segment decoder.
// SEG7_DEC_BIN_CONV_EN enables the serial BCD-to-binary CONV stage.
module seg7_frame_decoder
  import seg7_frame_decoder_pkg::*;
(
  input  logic             CLOCK_50,
  input  logic             reset_n,
  input  logic             frame_stb,
  input  logic [6:0]       seg2,
  input  logic [6:0]       seg1,
  input  logic [6:0]       seg0,
  output logic [VAL_W-1:0] bcd_out,
  output logic [VAL_W-1:0] value,
  output logic             valid,
  output logic             locked,
  output logic             err
);

  logic [3:0] w_d2, w_d1, w_d0;
  logic       w_b2, w_b1, w_b0;
  logic       w_i2, w_i1, w_i0;
  logic       w_all_blank, w_all_digit;

  seg7_to_bcd u_dec2 (.i_seg(seg2), .o_digit(w_d2),
                      .o_blank(w_b2), .o_illegal(w_i2));
  seg7_to_bcd u_dec1 (.i_seg(seg1), .o_digit(w_d1),
                      .o_blank(w_b1), .o_illegal(w_i1));
  seg7_to_bcd u_dec0 (.i_seg(seg0), .o_digit(w_d0),
                      .o_blank(w_b0), .o_illegal(w_i0));

  assign w_all_blank = w_b2 & w_b1 & w_b0;
  assign w_all_digit = ~(w_b2 | w_b1 | w_b0 |
                         w_i2 | w_i1 | w_i0);

  state_t           r_state, w_next;
  logic             w_err, w_done;
  logic             w_lat2, w_lat1, w_lat0;
  logic             r_err, r_done, r_valid, r_locked;
  logic [VAL_W-1:0] r_dig, r_bcd;

`ifdef SEG7_DEC_BIN_CONV_EN
  logic             w_start, w_sync_set;
  logic [ACC_W-1:0] r_acc;
  logic [VAL_W-1:0] r_sh;
  logic [VAL_W-1:0] r_value;
  logic [3:0]       r_cnt;
  logic             r_sync;
`endif

  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) r_state <= ST_HUNT;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    w_err  = 1'b0;
    w_done = 1'b0;
    w_lat2 = 1'b0;
    w_lat1 = 1'b0;
    w_lat0 = 1'b0;
`ifdef SEG7_DEC_BIN_CONV_EN
    w_start    = 1'b0;
    w_sync_set = 1'b0;
`endif
    unique case (r_state)
      ST_HUNT: begin
        if (frame_stb && w_all_blank) w_next = ST_G2;
      end
      ST_SYNC: begin
        if (frame_stb) begin
          if (w_all_blank) w_next = ST_G2;
          else begin
            w_err  = 1'b1;
            w_next = ST_HUNT;
          end
        end
      end
      ST_G2: begin
        if (frame_stb) begin
          if (w_all_digit) begin
            w_lat2 = 1'b1;
            w_next = ST_G1;
          end else if (!w_all_blank) begin
            w_err  = 1'b1;
            w_next = ST_HUNT;
          end
        end
      end
      ST_G1: begin
        if (frame_stb) begin
          w_err = ~w_all_digit;
          if (w_all_digit) begin
            w_lat1 = 1'b1;
            w_next = ST_G0;
          end else if (w_all_blank) w_next = ST_G2;
          else                      w_next = ST_HUNT;
        end
      end
      ST_G0: begin
        if (frame_stb) begin
          w_err = ~w_all_digit;
          if (w_all_digit) begin
            w_lat0 = 1'b1;
`ifdef SEG7_DEC_BIN_CONV_EN
            w_start = 1'b1;
            w_next  = ST_CONV;
`else
            w_done = 1'b1;
            w_next = ST_SYNC;
`endif
          end else if (w_all_blank) w_next = ST_G2;
          else                      w_next = ST_HUNT;
        end
      end
`ifdef SEG7_DEC_BIN_CONV_EN
      ST_CONV: begin
        // A blank on the last step still counts as a resync
        if (frame_stb && !w_all_blank) begin
          w_err  = 1'b1;
          w_next = ST_HUNT;
        end else if (r_cnt == 4'(DIGITS - 1)) begin
          w_done = 1'b1;
          w_next = (r_sync || frame_stb) ? ST_G2 : ST_SYNC;
        end else if (frame_stb) begin
          w_sync_set = 1'b1;
        end
      end
`endif
      default: w_next = ST_HUNT;
    endcase
  end

  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      r_err    <= 1'b0;
      r_done   <= 1'b0;
      r_valid  <= 1'b0;
      r_locked <= 1'b0;
      r_dig    <= '0;
      r_bcd    <= '0;
    end else begin
      r_err   <= w_err;
      r_done  <= w_done;
      r_valid <= r_done;
      if (w_lat2) r_dig[35:24] <= {w_d2, w_d1, w_d0};
      if (w_lat1) r_dig[23:12] <= {w_d2, w_d1, w_d0};
      if (w_lat0) r_dig[11:0]  <= {w_d2, w_d1, w_d0};
      if (r_done) r_bcd <= r_dig;
      if (w_err)       r_locked <= 1'b0;
      else if (r_done) r_locked <= 1'b1;
    end
  end

`ifdef SEG7_DEC_BIN_CONV_EN
  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      r_acc   <= '0;
      r_sh    <= '0;
      r_cnt   <= '0;
      r_sync  <= 1'b0;
      r_value <= '0;
    end else begin
      if (w_start) begin
        r_acc  <= '0;
        r_cnt  <= '0;
        r_sync <= 1'b0;
        r_sh   <= {r_dig[35:12], w_d2, w_d1, w_d0};
      end else if (r_state == ST_CONV) begin
        r_acc <= r_acc * ACC_W'(10) + ACC_W'(r_sh[35:32]);
        r_sh  <= {r_sh[31:0], 4'd0};
        r_cnt <= r_cnt + 4'd1;
        if (w_sync_set) r_sync <= 1'b1;
      end
      if (r_done) r_value <= VAL_W'(r_acc);
    end
  end

  assign value = r_value;
`else
  assign value = '0;
`endif

  assign bcd_out = r_bcd;
  assign valid   = r_valid;
  assign locked  = r_locked;
  assign err     = r_err;

endmodule

// File: tb/tb_seg7_frame_decoder.sv
// Directed bench for seg7_frame_decoder.
// Works with SEG7_DEC_BIN_CONV_EN defined or undefined.
module tb_seg7_frame_decoder;

  logic        CLOCK_50 = 1'b0;
  logic        reset_n;
  logic        frame_stb;
  logic [6:0]  seg2, seg1, seg0;
  logic [35:0] bcd_out, value;
  logic        valid, locked, err;

  int n_chk = 0;
  int n_err = 0;

`ifdef SEG7_DEC_BIN_CONV_EN
  localparam int LAT    = 10;
  localparam int RST_AT = 5;
`else
  localparam int LAT    = 1;
  localparam int RST_AT = 0;
`endif

  localparam logic [6:0] P [10] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100};
  localparam logic [6:0] PB = 7'b1111111;
  localparam logic [6:0] PA = 7'b0001000;

  seg7_frame_decoder dut (
    .CLOCK_50 (CLOCK_50),
    .reset_n  (reset_n),
    .frame_stb(frame_stb),
    .seg2     (seg2),
    .seg1     (seg1),
    .seg0     (seg0),
    .bcd_out  (bcd_out),
    .value    (value),
    .valid    (valid),
    .locked   (locked),
    .err      (err)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  task automatic chk(input string tag,
                     input logic [35:0] obs,
                     input logic [35:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s got %h want %h", tag, obs, exp);
    end
  endtask

  function automatic logic [35:0] ev(input logic [35:0] x);
`ifdef SEG7_DEC_BIN_CONV_EN
    return x;
`else
    return 36'd0;
`endif
  endfunction

  task automatic frame(input logic [6:0] a,
                       input logic [6:0] b,
                       input logic [6:0] c);
    @(negedge CLOCK_50);
    seg2 = a;
    seg1 = b;
    seg0 = c;
    frame_stb = 1'b1;
    @(posedge CLOCK_50);
    #1;
    frame_stb = 1'b0;
  endtask

  task automatic num(input int d2, input int d1, input int d0);
    frame(P[d2], P[d1], P[d0]);
  endtask

  task automatic blank();
    frame(PB, PB, PB);
  endtask

  task automatic expect_out(input string tag,
                            input logic [35:0] v,
                            input logic [35:0] b);
    logic early;
    early = 1'b0;
    for (int k = 1; k < LAT; k++) begin
      @(posedge CLOCK_50);
      #1;
      if (valid) early = 1'b1;
    end
    @(posedge CLOCK_50);
    #1;
    chk({tag, "_early"}, 36'(early), 36'd0);
    chk({tag, "_valid"}, 36'(valid), 36'd1);
    chk({tag, "_value"}, value, v);
    chk({tag, "_bcd"}, bcd_out, b);
    chk({tag, "_locked"}, 36'(locked), 36'd1);
    @(posedge CLOCK_50);
    #1;
    chk({tag, "_pulse"}, 36'(valid), 36'd0);
  endtask

  initial begin
    #200us;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic seen;
    reset_n   = 1'b0;
    frame_stb = 1'b0;
    seg2 = PB;
    seg1 = PB;
    seg0 = PB;
    repeat (3) @(posedge CLOCK_50);
    #1;
    chk("rst_valid", 36'(valid), 36'd0);
    chk("rst_err", 36'(err), 36'd0);
    chk("rst_locked", 36'(locked), 36'd0);
    chk("rst_value", value, 36'd0);
    chk("rst_bcd", bcd_out, 36'd0);
    @(negedge CLOCK_50);
    reset_n = 1'b1;

    blank();
    num(1, 2, 3);
    num(4, 5, 6);
    chk("pre_lock", 36'(locked), 36'd0);
    num(7, 8, 9);
    expect_out("t1", ev(36'h75BCD15), 36'h123456789);

    blank();
    num(9, 9, 9);
    num(9, 9, 9);
    num(9, 9, 9);
    expect_out("t2", ev(36'h3B9AC9FF), 36'h999999999);

    blank();
    num(1, 2, 3);
    chk("still_locked", 36'(locked), 36'd1);
    frame(P[1], PA, P[3]);
    chk("ill_err", 36'(err), 36'd1);
    chk("ill_locked", 36'(locked), 36'd0);
    chk("ill_value", value, ev(36'h3B9AC9FF));
    chk("ill_bcd", bcd_out, 36'h999999999);
    @(posedge CLOCK_50);
    #1;
    chk("ill_pulse", 36'(err), 36'd0);
    num(4, 5, 6);
    chk("hunt_ignore", 36'(err), 36'd0);

    blank();
    num(1, 2, 3);
    num(4, 5, 6);
    num(7, 8, 9);
`ifdef SEG7_DEC_BIN_CONV_EN
    seen = 1'b0;
    for (int k = 1; k <= LAT; k++) begin
      if (k == 3) begin
        blank();
        chk("conv_blank_err", 36'(err), 36'd0);
      end else begin
        @(posedge CLOCK_50);
        #1;
      end
      if (k < LAT && valid) seen = 1'b1;
    end
    chk("t3_early", 36'(seen), 36'd0);
    chk("t3_valid", 36'(valid), 36'd1);
    chk("t3_value", value, 36'h75BCD15);
`else
    expect_out("t3", ev(36'h75BCD15), 36'h123456789);
    blank();
`endif
    num(4, 5, 6);
    chk("g2_accept", 36'(err), 36'd0);
    num(7, 8, 9);
    num(1, 2, 3);
    expect_out("t4", ev(36'h1B3A0C83), 36'h456789123);

    num(1, 1, 1);
    chk("nosync_err", 36'(err), 36'd1);
    chk("nosync_locked", 36'(locked), 36'd0);
    num(2, 2, 2);
    chk("nosync_hunt", 36'(err), 36'd0);

    blank();
    num(1, 2, 3);
    num(4, 5, 6);
    num(7, 8, 9);
    repeat (RST_AT) begin
      @(posedge CLOCK_50);
      #1;
    end
    #2;
    reset_n = 1'b0;
    @(posedge CLOCK_50);
    #1;
    chk("mid_value", value, 36'd0);
    chk("mid_bcd", bcd_out, 36'd0);
    chk("mid_valid", 36'(valid), 36'd0);
    chk("mid_locked", 36'(locked), 36'd0);
    chk("mid_err", 36'(err), 36'd0);
    @(negedge CLOCK_50);
    reset_n = 1'b1;
    seen = 1'b0;
    repeat (15) begin
      @(posedge CLOCK_50);
      #1;
      if (valid) seen = 1'b1;
    end
    chk("mid_no_valid", 36'(seen), 36'd0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
